// File: rtl/toggle_cnt_pkg.sv
// Shared types and constants for the multi-channel toggle counter bank.
// Holds the default widths, the count-direction encoding and the select-width helper.
package toggle_cnt_pkg;

   localparam int DEFAULT_WIDTH       = 8;
   localparam int DEFAULT_SYNC_STAGES = 2;

   typedef logic [DEFAULT_WIDTH-1:0] cnt_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // A single channel still needs a one-bit select port.
   function automatic int sel_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/toggle_cnt_bank_tick_gen.sv
// Prescaler for the counter bank: emits a one-cycle tick every RATIO clocks.
// clr restarts the count so the next tick arrives RATIO cycles later.
module tick_gen #(
   parameter int RATIO = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int            PW   = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [PW-1:0] LAST = PW'(RATIO - 1);

   logic [PW-1:0] p;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p    <= '0;
         tick <= 1'b0;
      end else if (clr) begin
         p    <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (p == LAST);
         p    <= (p == LAST) ? '0 : p + 1'b1;
      end
   end

endmodule

// File: rtl/toggle_cnt_bank.sv
// Bank of switch-toggled up/down counters sharing one prescaled tick and one read bus.
// Define TOGGLE_CNT_BANK_SAT_EN to make counters saturate at their limits instead of wrapping.
module toggle_cnt_bank
   import toggle_cnt_pkg::*;
#(
   parameter  int WIDTH       = DEFAULT_WIDTH,
   parameter  int CHANNELS    = 4,
   parameter  int RATIO       = 10,
   parameter  int SYNC_STAGES = DEFAULT_SYNC_STAGES,
   localparam int SELW        = sel_width(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic [CHANNELS-1:0] sw,
   input  logic [CHANNELS-1:0] dir,
   input  logic [SELW-1:0]     sel,
   output logic [WIDTH-1:0]    data,
   output logic [CHANNELS-1:0] run,
   output logic [CHANNELS-1:0] tc,
   output logic                tick
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] cnt    [CHANNELS];
   logic [WIDTH-1:0] cnt_rd [2**SELW];

   tick_gen #(.RATIO(RATIO)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .tick  (tick)
   );

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   sync_d;
      logic                   rise;
      logic                   run_q;
      logic                   tc_q;
      logic [WIDTH-1:0]       cnt_q;

      // NOTE: synchroniser and edge flops take rst_n only; clr must not fabricate or swallow edges later.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_q <= '0;
            sync_d <= 1'b0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw[i]};
            sync_d <= sync_q[SYNC_STAGES-1];
         end
      end

      assign rise = sync_q[SYNC_STAGES-1] & ~sync_d;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
            tc_q  <= 1'b0;
         end else if (clr) begin
            cnt_q <= '0;
            run_q <= 1'b0;
            tc_q  <= 1'b0;
         end else begin
            tc_q <= 1'b0;
            if (rise) run_q <= ~run_q;
            // The step sees run_q before this edge's toggle.
            if (tick && run_q) begin
               if (dir_e'(dir[i]) == DIR_DOWN) begin
`ifdef TOGGLE_CNT_BANK_SAT_EN
                  if (cnt_q != '0) begin
                     cnt_q <= cnt_q - 1'b1;
                     tc_q  <= (cnt_q == WIDTH'(1));
                  end
`else
                  cnt_q <= cnt_q - 1'b1;
                  tc_q  <= (cnt_q == '0);
`endif
               end else begin
`ifdef TOGGLE_CNT_BANK_SAT_EN
                  if (cnt_q != CNT_MAX) begin
                     cnt_q <= cnt_q + 1'b1;
                     tc_q  <= (cnt_q == CNT_MAX - 1'b1);
                  end
`else
                  cnt_q <= cnt_q + 1'b1;
                  tc_q  <= (cnt_q == CNT_MAX);
`endif
               end
            end
         end
      end

      assign cnt[i] = cnt_q;
      assign run[i] = run_q;
      assign tc[i]  = tc_q;
   end

   // Pad the read mux to the full select range so out-of-range selects read zero.
   for (genvar j = 0; j < 2**SELW; j++) begin : g_rd
      if (j < CHANNELS) begin : g_used
         assign cnt_rd[j] = cnt[j];
      end else begin : g_zero
         assign cnt_rd[j] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
      end else if (clr) begin
         data <= '0;
      end else begin
         data <= cnt_rd[sel];
      end
   end

endmodule

// File: tb/tb_toggle_cnt_bank.sv
// Self-checking bench for toggle_cnt_bank: directed cases on a default instance, and a table
// plus randomized model comparison on a small fast instance (WIDTH=3, CHANNELS=3, RATIO=1).
module tb_toggle_cnt_bank;

`ifdef TOGGLE_CNT_BANK_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam int BW   = 3;
   localparam int BCH  = 3;
   localparam int BR   = 1;
   localparam int BS   = 2;
   localparam int BMAX = (1 << BW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       a_clr = 0;
   logic [3:0] a_sw = 0, a_dir = 0;
   logic [1:0] a_sel = 0;
   logic [7:0] a_data;
   logic [3:0] a_run, a_tc;
   logic       a_tick;

   logic       b_clr = 0;
   logic [2:0] b_sw = 0, b_dir = 0;
   logic [1:0] b_sel = 0;
   logic [2:0] b_data, b_run, b_tc;
   logic       b_tick;

   toggle_cnt_bank #(.WIDTH(8), .CHANNELS(4), .RATIO(10), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .clr(a_clr), .sw(a_sw), .dir(a_dir), .sel(a_sel),
      .data(a_data), .run(a_run), .tc(a_tc), .tick(a_tick)
   );

   toggle_cnt_bank #(.WIDTH(BW), .CHANNELS(BCH), .RATIO(BR), .SYNC_STAGES(BS)) dut_b (
      .clk(clk), .rst_n(rst_n), .clr(b_clr), .sw(b_sw), .dir(b_dir), .sel(b_sel),
      .data(b_data), .run(b_run), .tc(b_tc), .tick(b_tick)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      a_clr = 0; a_sw = 0; a_dir = 0; a_sel = 0;
      b_clr = 0; b_sw = 0; b_dir = 0; b_sel = 0;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   // Channel-0 count expected on dut_a, accumulated from observed tick/run before each edge.
   bit [7:0] a0_exp;
   task automatic step_a();
      if (a_tick && a_run[0]) a0_exp = a0_exp + 8'd1;
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model of dut_b ----------------
   int m_cnt  [BCH];
   bit m_run  [BCH];
   bit m_tc   [BCH];
   bit m_h    [BCH][BS+2];   // m_h[i][k]: sw[i] as sampled k+1 edges ago
   bit m_tick;
   int m_since;
   int m_data;

   task automatic model_reset();
      for (int i = 0; i < BCH; i++) begin
         m_cnt[i] = 0; m_run[i] = 0; m_tc[i] = 0;
         for (int k = 0; k < BS + 2; k++) m_h[i][k] = 0;
      end
      m_tick = 0; m_since = 0; m_data = 0;
   endtask

   task automatic model_edge();
      bit rise [BCH];
      for (int i = 0; i < BCH; i++) begin
         // A press sampled BS edges ago after a low sample toggles run now.
         rise[i] = m_h[i][BS-1] && !m_h[i][BS];
         for (int k = BS + 1; k > 0; k--) m_h[i][k] = m_h[i][k-1];
         m_h[i][0] = b_sw[i];
      end
      if (b_clr) begin
         for (int i = 0; i < BCH; i++) begin
            m_cnt[i] = 0; m_run[i] = 0; m_tc[i] = 0;
         end
         m_tick = 0; m_since = 0; m_data = 0;
      end else begin
         m_data = (int'(b_sel) < BCH) ? m_cnt[b_sel] : 0;
         for (int i = 0; i < BCH; i++) begin
            m_tc[i] = 0;
            if (m_tick && m_run[i]) begin
               if (b_dir[i]) begin
                  if (SAT) begin
                     if (m_cnt[i] > 0) begin m_cnt[i]--; m_tc[i] = (m_cnt[i] == 0); end
                  end else begin
                     m_tc[i]  = (m_cnt[i] == 0);
                     m_cnt[i] = (m_cnt[i] == 0) ? BMAX : m_cnt[i] - 1;
                  end
               end else begin
                  if (SAT) begin
                     if (m_cnt[i] < BMAX) begin m_cnt[i]++; m_tc[i] = (m_cnt[i] == BMAX); end
                  end else begin
                     m_tc[i]  = (m_cnt[i] == BMAX);
                     m_cnt[i] = (m_cnt[i] + 1) % (BMAX + 1);
                  end
               end
            end
            if (rise[i]) m_run[i] = !m_run[i];
         end
         m_since++;
         m_tick = (m_since % BR) == 0;
      end
   endtask

   typedef struct {
      logic       clr;
      logic [2:0] sw;
      logic [2:0] dir;
      logic [1:0] sel;
      logic [2:0] data;
      logic [2:0] run;
      logic [2:0] tc;
      logic       tick;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [10];
      int   e, n, pulses;
      logic [2:0] rv, tv;

      //            clr   sw      dir     sel   data  run     tc      tick
      tbl[0] = '{1'b0, 3'b001, 3'b000, 2'd0, 3'd0, 3'b000, 3'b000, 1'b1};
      tbl[1] = '{1'b0, 3'b001, 3'b000, 2'd0, 3'd0, 3'b000, 3'b000, 1'b1};
      tbl[2] = '{1'b0, 3'b001, 3'b000, 2'd0, 3'd0, 3'b001, 3'b000, 1'b1};
      tbl[3] = '{1'b0, 3'b001, 3'b000, 2'd0, 3'd0, 3'b001, 3'b000, 1'b1};
      tbl[4] = '{1'b0, 3'b001, 3'b000, 2'd0, 3'd1, 3'b001, 3'b000, 1'b1};
      tbl[5] = '{1'b0, 3'b001, 3'b001, 2'd0, 3'd2, 3'b001, 3'b000, 1'b1};
      tbl[6] = '{1'b0, 3'b001, 3'b000, 2'd3, 3'd0, 3'b001, 3'b000, 1'b1};
      tbl[7] = '{1'b1, 3'b001, 3'b000, 2'd0, 3'd0, 3'b000, 3'b000, 1'b0};
      tbl[8] = '{1'b0, 3'b001, 3'b000, 2'd0, 3'd0, 3'b000, 3'b000, 1'b1};
      tbl[9] = '{1'b0, 3'b000, 3'b000, 2'd0, 3'd0, 3'b000, 3'b000, 1'b1};

      // ---- dut_a: reset state and first tick ----
      do_reset();
      check("a_reset_data", a_data, 0);
      check("a_reset_run", a_run, 0);
      check("a_reset_tc", a_tc, 0);
      check("a_reset_tick", a_tick, 0);
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         check($sformatf("a_first_tick_c%0d", k), a_tick, (k == 10));
      end

      // ---- dut_b: table-driven vectors from reset ----
      do_reset();
      check("b_reset_run", b_run, 0);
      for (int r = 0; r < 10; r++) begin
         b_clr = tbl[r].clr; b_sw = tbl[r].sw; b_dir = tbl[r].dir; b_sel = tbl[r].sel;
         @(posedge clk); #1;
         check($sformatf("tbl%0d_data", r), b_data, tbl[r].data);
         check($sformatf("tbl%0d_run", r), b_run, tbl[r].run);
         check($sformatf("tbl%0d_tc", r), b_tc, tbl[r].tc);
         check($sformatf("tbl%0d_tick", r), b_tick, tbl[r].tick);
      end

      // ---- dut_a: toggle latency, five ticks, stop ----
      do_reset();
      a0_exp = 0;
      a_sw[0] = 1'b1;
      e = 0;
      for (int g = 1; g <= 8; g++) begin
         step_a();
         if (a_run[0]) begin e = g; break; end
      end
      check("a_toggle_latency", e, 3);
      n = 0;
      for (int g = 0; g < 100; g++) begin
         if (a_tick) n++;
         if (n == 5) break;
         step_a();
      end
      step_a(); step_a();
      check("a_count5_data", a_data, 5);

      a_sw[0] = 1'b0;
      repeat (4) step_a();
      a_sw[0] = 1'b1;
      e = 0;
      for (int g = 1; g <= 8; g++) begin
         step_a();
         if (!a_run[0]) begin e = g; break; end
      end
      check("a_stop_latency", e, 3);
      repeat (28) step_a();
      check("a_stopped_data", a_data, a0_exp);

      // ---- dut_a: channel 1 counting down from zero ----
      a_clr = 1'b1; step_a(); a_clr = 1'b0;
      check("a_clr_run", a_run, 0);
      check("a_clr_data", a_data, 0);
      a_dir[1] = 1'b1; a_sel = 2'd1; a_sw[1] = 1'b1;
      for (int g = 0; g < 10 && !a_run[1]; g++) step_a();
      check("a_run1_on", a_run[1], 1);
      for (int g = 0; g < 20 && !a_tick; g++) step_a();
      check("a_tick_wait", a_tick, 1);
      step_a();
      check("a_down_tc1", a_tc[1], SAT ? 0 : 1);
      step_a();
      check("a_down_data", a_data, SAT ? 0 : 255);
      check("a_down_tc1_single", a_tc[1], 0);

      // ---- dut_a: clr on the same edge as a tick and an sw[3] toggle ----
      for (int g = 0; g < 20 && !a_tick; g++) step_a();
      repeat (8) step_a();
      a_sw[3] = 1'b1;
      step_a(); step_a();
      check("a_tick_before_clr", a_tick, 1);
      a_clr = 1'b1; step_a(); a_clr = 1'b0;
      check("a_clr2_run", a_run, 0);
      check("a_clr2_tick", a_tick, 0);
      check("a_clr2_tc", a_tc, 0);
      check("a_clr2_data", a_data, 0);
      for (int k = 1; k <= 10; k++) begin
         step_a();
         check($sformatf("a_retick_c%0d", k), a_tick, (k == 10));
      end
      check("a_run3_after_clr", a_run[3], 0);
      check("a_data_after_clr", a_data, 0);

      // ---- dut_a: asynchronous reset mid-count ----
      a_sel = 2'd0; a_dir = 4'b0000; a_sw[0] = 1'b0;
      repeat (4) step_a();
      a_sw[0] = 1'b1;
      for (int g = 0; g < 60 && a_data == 0; g++) step_a();
      check("a_counting_before_rst", a_data != 0, 1);
      #2 rst_n = 1'b0;
      #1;
      check("a_async_rst_data", a_data, 0);
      check("a_async_rst_run", a_run, 0);
      check("a_async_rst_tc", a_tc, 0);
      check("a_async_rst_tick", a_tick, 0);

      // ---- dut_b: randomized against the model ----
      do_reset();
      model_reset();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < BCH; i++)
            if ($urandom_range(0, 5) == 0) b_sw[i] = ~b_sw[i];
         b_dir = 3'($urandom_range(0, 7));
         b_sel = 2'($urandom_range(0, 3));
         b_clr = ($urandom_range(0, 49) == 0);
         model_edge();
         @(posedge clk); #1;
         for (int i = 0; i < BCH; i++) begin
            rv[i] = m_run[i];
            tv[i] = m_tc[i];
         end
         check($sformatf("rand%0d_data", c), b_data, m_data);
         check($sformatf("rand%0d_run", c), b_run, rv);
         check($sformatf("rand%0d_tc", c), b_tc, tv);
         check($sformatf("rand%0d_tick", c), b_tick, m_tick);
      end

      // ---- dut_b: channel 2 counting up through its limit, RATIO=1 ----
      do_reset();
      b_sel = 2'd2; b_sw[2] = 1'b1;
      for (int g = 0; g < 10 && !b_run[2]; g++) begin
         @(posedge clk); #1;
      end
      check("b_run2_on", b_run[2], 1);
      pulses = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (b_tc[2]) pulses++;
      end
      check("b_limit_tc_pulses", pulses, SAT ? 1 : 3);
      check("b_limit_data", b_data, SAT ? BMAX : 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/toggle_cnt_bank.md
# toggle_cnt_bank

Parametrised multi-channel successor to the single-channel switch-toggled counter in the top level. Each channel has its own switch input, which is synchronised and edge-detected so that every press toggles that channel's run state. While a channel runs, it counts up or down on a shared prescaled tick. Any channel's count can be read on one registered output bus; per-channel terminal-count pulses are provided for downstream sequencing.

## Interface
- WIDTH, 8, counter width per channel (≥2)
- CHANNELS, 4, number of independent channels (≥1)
- RATIO, 10, clk cycles per prescaler tick (≥1)
- SYNC_STAGES, 2, switch synchroniser depth (≥2)
- SELW, max(1,$clog2(CHANNELS)), derived localparam, select width

- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- clr  in  1  synchronous clear of counts, run flags and prescaler
- sw  in  CHANNELS  asynchronous switch levels; a rising edge toggles run
- dir  in  CHANNELS  count direction per channel; 0 = up, 1 = down; synchronous to clk
- sel  in  SELW  read channel select; values ≥ CHANNELS read as zero
- data  out  WIDTH  registered count of the selected channel
- run  out  CHANNELS  current run flag per channel
- tc  out  CHANNELS  one-cycle terminal-count pulse per channel
- tick  out  1  prescaler tick, one cycle wide

## Operation
- Reset (rst_n low): all outputs and internal state go to 0, including synchroniser flops and counts.
- Prescaler:
  - count p runs 0..RATIO-1 and wraps to 0.
  - tick = (p == RATIO-1), registered.
  - RATIO = 1 gives tick constantly high, starting on the first edge after reset release.
- Switch path, per channel:
  - sw passes through SYNC_STAGES flops, then a one-flop edge detector.
  - A synchronised rising edge sets run[i] <= ~run[i].
  - Falling edges have no effect.
- Counter, per channel: when tick && run[i], cnt[i] steps by ±1 according to dir[i].
- Wrap (default):
  - up from 2^WIDTH-1 goes to 0; down from 0 goes to 2^WIDTH-1.
  - tc[i] pulses on the wrapping step only.
- clr: cnt, run, p, tick, tc and data are all cleared on that edge. clr has priority over toggle and count. Synchroniser flops are not cleared.
- Read: data <= (sel < CHANNELS) ? cnt[sel] : '0, every cycle.

## Timing
- Toggle latency: run[i] changes on the (SYNC_STAGES+1)th rising edge after the first edge sampling sw[i] high. With the default, this is the 3rd edge.
- First tick: tick is high RATIO cycles after reset release, then every RATIO cycles.
- Same edge as a toggle: a count step on that edge uses the pre-toggle run value.
- tc timing: tc[i] is high in the cycle after the wrapping edge, aligned with the new cnt value. It is never high on two consecutive cycles unless RATIO = 1.
- dir: sampled on the counting edge. A dir change takes effect on the next tick.
- data latency: 1 cycle after a change of sel or cnt.
- Reset mid-count: asynchronous clear; no tc is emitted.

## Configuration
- Macro TOGGLE_CNT_BANK_SAT_EN.
- Defined: counters saturate instead of wrapping. Up holds at 2^WIDTH-1 and down holds at 0. tc[i] pulses once, on the step that reaches the limit. While a channel is held at a limit, further ticks neither change cnt nor pulse tc.
- Undefined: wrap behaviour as in Operation.

## Structure
- Package toggle_cnt_pkg:
  - typedef cnt_t as logic [WIDTH-1:0]-style parameterised via a localparam default.
  - enum dir_e {DIR_UP=0, DIR_DOWN=1}.
  - Constant DEFAULT_SYNC_STAGES = 2.
- Sub-module tick_gen (parameter RATIO; ports clk, rst_n, clr, tick) holds the prescaler. It has no other sub-modules.
- Channels are built with a generate loop in the top module.

## Test plan
- Reset release, WIDTH=8, RATIO=10, CHANNELS=4 → tick first high at cycle 10; run, cnt, tc and data all 0.
- sw[0] 0→1 held → run[0]=1 on the 3rd edge. After 5 ticks with dir=0 and sel=0, data=5. sw[0] pulsed again → counting stops at its current value.
- Channel 1, dir=1, start at 0, one tick → cnt=255 and tc[1] pulses. With TOGGLE_CNT_BANK_SAT_EN defined: cnt stays 0 and no tc.
- Channel 2 at 254 counting up, RATIO=1, saturation build → 255 with a single tc pulse; 20 further cycles give no change and no tc.
- clr asserted on the same edge as a tick and an sw[3] toggle edge → next cycle all cnt=0 and run=0; tick restarts and is high RATIO cycles later.
- sel=5 with CHANNELS=4 → data=0 one cycle later. rst_n dropped mid-count → all outputs 0 immediately, without waiting for a clk edge.
